// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply datapath.
// Holds the dot-product FSM state encoding and a clog2 helper.
package matmul_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_VEC_LEN = 4;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Operand-pair input stream and result output stream of the
// dot-product accumulator; slave is the accumulator side.
interface dot_product_accumulator_if
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = 2 * DATA_W + clog2(DEF_VEC_LEN)
);
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData_A;
    logic [DATA_W-1:0] inData_B;
    logic              outValid;
    logic              outReady;
    logic [ACC_W-1:0]  outData_C;
    logic              outOverflow;

    modport master (
        output inValid, inData_A, inData_B, outReady,
        input  inReady, outValid, outData_C, outOverflow
    );

    modport slave (
        input  inValid, inData_A, inData_B, outReady,
        output inReady, outValid, outData_C, outOverflow
    );
endinterface

// File: rtl/vedicmultiplier_nbit.sv
// Combinational unsigned N x N Vedic multiplier, built recursively
// from 2-bit Vedic cells (four half-width products plus adders).
module vedicmultiplier_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    generate
        if (N == 2) begin : g_cell
            logic c;
            assign p[0] = a[0] & b[0];
            assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign c    = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[2] = (a[1] & b[1]) ^ c;
            assign p[3] = (a[1] & b[1]) & c;
        end else begin : g_rec
            localparam int H = N / 2;
            logic [N-1:0]   ll, lh, hl, hh;
            logic [2*N-1:0] mid;

            vedicmultiplier_nbit #(.N(H)) u_ll (
                .a(a[H-1:0]), .b(b[H-1:0]), .p(ll)
            );
            vedicmultiplier_nbit #(.N(H)) u_lh (
                .a(a[H-1:0]), .b(b[N-1:H]), .p(lh)
            );
            vedicmultiplier_nbit #(.N(H)) u_hl (
                .a(a[N-1:H]), .b(b[H-1:0]), .p(hl)
            );
            vedicmultiplier_nbit #(.N(H)) u_hh (
                .a(a[N-1:H]), .b(b[N-1:H]), .p(hh)
            );

            // cross terms sit at weight 2^H
            assign mid = {{H{1'b0}}, lh, {H{1'b0}}}
                       + {{H{1'b0}}, hl, {H{1'b0}}};
            assign p   = {hh, ll} + mid;
        end
    endgenerate
endmodule

// File: rtl/dot_product_accumulator.sv
// Sequential multiply-accumulate producing one dot-product element.
// Define DOTACC_SATURATE_EN for a saturating accumulator with sticky overflow.
module dot_product_accumulator
    import matmul_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int ACC_W   = 2 * DATA_W + clog2(VEC_LEN)
) (
    input  logic clk,
    input  logic rst,
    dot_product_accumulator_if.slave bus
);
    localparam int CNT_W = clog2(VEC_LEN);
    localparam int PW    = 2 * DATA_W;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             ready;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    p_q;
    logic             p_vld;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] res_q;
    logic             out_vld_q;
    logic             take, last, hs, load;

    vedicmultiplier_nbit #(.N(DATA_W)) u_mul (
        .a(bus.inData_A),
        .b(bus.inData_B),
        .p(prod)
    );

    assign take = bus.inValid & ready;
    assign last = (cnt_q == CNT_W'(VEC_LEN - 1));
    assign hs   = out_vld_q & bus.outReady;
    // result is captured one cycle after the final add has settled in acc
    assign load = (state_q == DONE) & ~out_vld_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        unique case (state_q)
            ACCUM: begin
                ready = run_q;
                if (take) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: state_d = DONE;
            DONE: if (hs) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            p_q       <= '0;
            p_vld     <= 1'b0;
            acc_q     <= '0;
            res_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            p_vld   <= take;
            if (take) p_q <= prod;
            if (hs) acc_q <= '0;
            else if (p_vld) acc_q <= acc_d;
            if (hs) begin
                out_vld_q <= 1'b0;
            end else if (load) begin
                out_vld_q <= 1'b1;
                res_q     <= acc_q;
            end
        end
    end

`ifdef DOTACC_SATURATE_EN
    logic [ACC_W:0] sum;
    logic           ovf_q;
    logic           res_ovf_q;

    assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(p_q);
    assign acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            if (hs) ovf_q <= 1'b0;
            else if (p_vld && sum[ACC_W]) ovf_q <= 1'b1;
            if (hs) res_ovf_q <= 1'b0;
            else if (load) res_ovf_q <= ovf_q;
        end
    end

    assign bus.outOverflow = res_ovf_q & out_vld_q;
`else
    assign acc_d           = acc_q + ACC_W'(p_q);
    assign bus.outOverflow = 1'b0;
`endif

    assign bus.inReady   = ready;
    assign bus.outValid  = out_vld_q;
    assign bus.outData_C = res_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench: a default-width unit (ACC_W=18) and a narrow one
// (ACC_W=16) share stimulus so wrap/saturation can be observed.
module tb_dot_product_accumulator;
    import matmul_pkg::*;

`ifdef DOTACC_SATURATE_EN
    localparam logic [31:0] NARROW_MAX = 32'd65535;
    localparam logic        NARROW_OVF = 1'b1;
`else
    localparam logic [31:0] NARROW_MAX = 32'd63492;
    localparam logic        NARROW_OVF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       iv;
    logic [7:0] a, b;
    logic       ordy;
    int         checks;
    int         errors;

    dot_product_accumulator_if #(.DATA_W(8), .ACC_W(18)) bus0 ();
    dot_product_accumulator_if #(.DATA_W(8), .ACC_W(16)) bus1 ();

    assign bus0.inValid  = iv;
    assign bus0.inData_A = a;
    assign bus0.inData_B = b;
    assign bus0.outReady = ordy;
    assign bus1.inValid  = iv;
    assign bus1.inData_A = a;
    assign bus1.inData_B = b;
    assign bus1.outReady = ordy;

    dot_product_accumulator #(
        .DATA_W(8), .VEC_LEN(4), .ACC_W(18)
    ) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    dot_product_accumulator #(
        .DATA_W(8), .VEC_LEN(4), .ACC_W(16)
    ) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_rdy0"}, 32'(bus0.inReady), 0);
        check({tag, "_vld0"}, 32'(bus0.outValid), 0);
        check({tag, "_dat0"}, 32'(bus0.outData_C), 0);
        check({tag, "_ovf0"}, 32'(bus0.outOverflow), 0);
        check({tag, "_rdy1"}, 32'(bus1.inReady), 0);
        check({tag, "_vld1"}, 32'(bus1.outValid), 0);
        check({tag, "_dat1"}, 32'(bus1.outData_C), 0);
        check({tag, "_ovf1"}, 32'(bus1.outOverflow), 0);
    endtask

    // va/vb hold four bytes, first beat in the top byte
    task automatic run(input string tag,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic o0, input logic o1);
        check({tag, "_start_rdy"}, 32'(bus0.inReady), 1);
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1;
            a  = va[8*(3-i) +: 8];
            b  = vb[8*(3-i) +: 8];
            tick();
        end
        iv = 1'b0;
        check({tag, "_busy_rdy"}, 32'(bus0.inReady), 0);
        check({tag, "_early_vld"}, 32'(bus0.outValid), 0);
        tick();
        check({tag, "_drain_vld"}, 32'(bus0.outValid), 0);
        tick();
        check({tag, "_vld0"}, 32'(bus0.outValid), 1);
        check({tag, "_dat0"}, 32'(bus0.outData_C), e0);
        check({tag, "_ovf0"}, 32'(bus0.outOverflow), 32'(o0));
        check({tag, "_vld1"}, 32'(bus1.outValid), 1);
        check({tag, "_dat1"}, 32'(bus1.outData_C), e1);
        check({tag, "_ovf1"}, 32'(bus1.outOverflow), 32'(o1));
        tick();
        check({tag, "_hs_vld"}, 32'(bus0.outValid), 0);
        check({tag, "_hs_rdy"}, 32'(bus0.inReady), 1);
        check({tag, "_hs_ovf1"}, 32'(bus1.outOverflow), 0);
    endtask

    initial begin
        logic [31:0] bpa, bpb;
        int          k;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        iv     = 1'b0;
        a      = '0;
        b      = '0;
        ordy   = 1'b1;
        #3;
        chk_zero("reset");
        #9 rst = 1'b0;
        tick();
        check("rdy_after_rst0", 32'(bus0.inReady), 1);
        check("rdy_after_rst1", 32'(bus1.inReady), 1);

        run("basic", {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
            32'd70, 32'd70, 1'b0, 1'b0);

        run("max", {4{8'd255}}, {4{8'd255}},
            32'd260100, NARROW_MAX, 1'b0, NARROW_OVF);

        // bubbles between beats, then a stalled consumer
        ordy = 1'b0;
        bpa  = {8'd2, 8'd4, 8'd6, 8'd8};
        bpb  = {8'd3, 8'd5, 8'd7, 8'd9};
        k    = 0;
        for (int i = 0; i < 7; i++) begin
            iv = (i % 2 == 0);
            if (iv) begin
                a = bpa[8*(3-k) +: 8];
                b = bpb[8*(3-k) +: 8];
                k++;
            end else begin
                a = 8'd99;
                b = 8'd99;
            end
            tick();
        end
        iv = 1'b0;
        check("bp_busy_rdy", 32'(bus0.inReady), 0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_vld", 32'(bus0.outValid), 1);
            check("bp_hold_dat", 32'(bus0.outData_C), 140);
            check("bp_hold_rdy", 32'(bus0.inReady), 0);
            check("bp_hold_dat1", 32'(bus1.outData_C), 140);
            iv = 1'b1;
            a  = 8'd99;
            b  = 8'd99;
            tick();
        end
        iv   = 1'b0;
        ordy = 1'b1;
        check("bp_last_vld", 32'(bus0.outValid), 1);
        check("bp_last_dat", 32'(bus0.outData_C), 140);
        tick();
        check("bp_hs_vld", 32'(bus0.outValid), 0);
        check("bp_hs_dat", 32'(bus0.outData_C), 140);
        run("after_bp", {8'd10, 8'd1, 8'd0, 8'd3},
            {8'd10, 8'd2, 8'd5, 8'd3},
            32'd111, 32'd111, 1'b0, 1'b0);

        // asynchronous reset after two of four beats
        iv = 1'b1;
        a  = 8'd5;
        b  = 8'd5;
        tick();
        tick();
        iv = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        tick();
        chk_zero("rst_hold");
        #2 rst = 1'b0;
        tick();
        check("rdy_after_rst_mid", 32'(bus0.inReady), 1);
        run("post_rst", {4{8'd1}}, {4{8'd1}},
            32'd4, 32'd4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
